// File: rtl/hack_cpu_pkg.sv
// rtl/hack_cpu_pkg.sv - shared FSM state encoding and Hack C-instruction field positions
package hack_cpu_pkg;

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      DECODE,
      MEM_RD,
      EXEC,
      MEM_WR,
      HALT
   } cpuState_e;

   localparam int A_SEL_BIT  = 12;
   localparam int COMP_LSB   = 6;
   localparam int DEST_A_BIT = 5;
   localparam int DEST_D_BIT = 4;
   localparam int DEST_M_BIT = 3;
   localparam int JMP_LT_BIT = 2;
   localparam int JMP_EQ_BIT = 1;
   localparam int JMP_GT_BIT = 0;

   localparam logic OPCODE_C = 1'b1;

   function automatic logic jumpTaken(input logic [2:0] jmp, input logic zr, input logic ng);
      return (jmp[JMP_LT_BIT] & ng) | (jmp[JMP_EQ_BIT] & zr) | (jmp[JMP_GT_BIT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// rtl/hack_cpu_mc_if.sv - instruction and data memory req/ack bus of the multi-cycle Hack CPU
interface hack_cpu_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              dmem_rd;
   logic              dmem_wr;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/hack_cpu_mc_alu.sv
// rtl/hack_cpu_mc_alu.sv - combinational Hack ALU (zx/nx/zy/ny/f/no) of generic width
module hack_alu_w #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              zx,
   input  logic              nx,
   input  logic              zy,
   input  logic              ny,
   input  logic              f,
   input  logic              no,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);
   logic [DATA_W-1:0] xz, xn, yz, yn, fOut;

   always_comb begin
      xz   = zx ? '0 : x;
      xn   = nx ? ~xz : xz;
      yz   = zy ? '0 : y;
      yn   = ny ? ~yz : yz;
      fOut = f ? (xn + yn) : (xn & yn);
      out  = no ? ~fOut : fOut;
   end

   assign zr = (out == '0);
   assign ng = out[DATA_W-1];
endmodule

// File: rtl/hack_cpu_mc.sv
// rtl/hack_cpu_mc.sv - multi-cycle Hack CPU with req/ack memories; HACK_CPU_HALT_EN halts on a taken self-loop
module hack_cpu_mc #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   hack_cpu_mc_if.master     bus,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);
   import hack_cpu_pkg::*;

   cpuState_e state, stateNext;

   logic [DATA_W-1:0] aReg, dReg, ir, mReg;
   logic [DATA_W-1:0] aluOut;
   logic              aluZr, aluNg;
   logic [ADDR_W-1:0] pcPlus1;
   logic              isC, aSel, destA, destD, destM;
   logic [2:0]        jmp;
   logic              iAck, dAck, taken, haltHit;
   logic              loadIr, aInstr, loadM, latchWr, commit;

   assign isC   = (ir[DATA_W-1] == OPCODE_C);
   assign aSel  = ir[A_SEL_BIT];
   assign destA = ir[DEST_A_BIT];
   assign destD = ir[DEST_D_BIT];
   assign destM = ir[DEST_M_BIT];
   assign jmp   = ir[JMP_LT_BIT:JMP_GT_BIT];

   // acks only count while the matching request is actually outstanding
   assign iAck = bus.imem_ack & bus.imem_req;
   assign dAck = bus.dmem_ack & (bus.dmem_rd | bus.dmem_wr);

   assign pcPlus1 = pc + ADDR_W'(1);

   hack_alu_w #(.DATA_W(DATA_W)) alu (
      .x  (dReg),
      .y  (aSel ? mReg : aReg),
      .zx (ir[COMP_LSB+5]),
      .nx (ir[COMP_LSB+4]),
      .zy (ir[COMP_LSB+3]),
      .ny (ir[COMP_LSB+2]),
      .f  (ir[COMP_LSB+1]),
      .no (ir[COMP_LSB]),
      .out(aluOut),
      .zr (aluZr),
      .ng (aluNg)
   );

   // operands are untouched until commit, so the ALU result is still valid in MEM_WR
   assign taken = jumpTaken(jmp, aluZr, aluNg);

`ifdef HACK_CPU_HALT_EN
   assign haltHit = (jmp == 3'b111) && (aReg[ADDR_W-1:0] == pc);
   assign halted  = (state == HALT);
`else
   assign haltHit = 1'b0;
   assign halted  = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BOOT;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         BOOT:    stateNext = FETCH;
         FETCH:   if (iAck) stateNext = DECODE;
         DECODE:  if (!isC)     stateNext = FETCH;
                  else if (aSel) stateNext = MEM_RD;
                  else           stateNext = EXEC;
         MEM_RD:  if (dAck) stateNext = EXEC;
         EXEC:    if (destM)        stateNext = MEM_WR;
                  else if (haltHit) stateNext = HALT;
                  else              stateNext = FETCH;
         MEM_WR:  if (dAck) stateNext = haltHit ? HALT : FETCH;
         HALT:    stateNext = HALT;
         default: stateNext = BOOT;
      endcase
   end

   always_comb begin
      loadIr  = (state == FETCH) && iAck;
      aInstr  = (state == DECODE) && !isC;
      loadM   = (state == MEM_RD) && dAck;
      latchWr = (state == EXEC) && destM;
      commit  = ((state == EXEC) && !destM) || ((state == MEM_WR) && dAck);
   end

   assign bus.imem_addr = pc;
   assign bus.dmem_addr = aReg[ADDR_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc             <= '0;
         aReg           <= '0;
         dReg           <= '0;
         ir             <= '0;
         mReg           <= '0;
         bus.imem_req   <= 1'b0;
         bus.dmem_rd    <= 1'b0;
         bus.dmem_wr    <= 1'b0;
         bus.dmem_wdata <= '0;
      end else begin
         bus.imem_req <= (stateNext == FETCH);
         bus.dmem_rd  <= (stateNext == MEM_RD);
         bus.dmem_wr  <= (stateNext == MEM_WR);
         if (loadIr)  ir             <= bus.imem_rdata;
         if (loadM)   mReg           <= bus.dmem_rdata;
         if (latchWr) bus.dmem_wdata <= aluOut;
         if (aInstr) begin
            aReg <= {1'b0, ir[DATA_W-2:0]};
            pc   <= pcPlus1;
         end
         // jump target reads the pre-commit A thanks to non-blocking update
         if (commit) begin
            if (destA) aReg <= aluOut;
            if (destD) dReg <= aluOut;
            pc <= taken ? aReg[ADDR_W-1:0] : pcPlus1;
         end
      end
   end
endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb/tb_hack_cpu_mc.sv - directed self-checking bench for hack_cpu_mc
module tb_hack_cpu_mc;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sreset = 1'b1;
   always #5 clk = ~clk;

   hack_cpu_mc_if #(.DATA_W(16), .ADDR_W(15)) bus ();
   hack_cpu_mc_if #(.DATA_W(16), .ADDR_W(4))  sbus ();

   logic [14:0] pc;
   logic        halted;
   logic [3:0]  spc;
   logic        shalted;

   hack_cpu_mc #(.DATA_W(16), .ADDR_W(15)) dut (
      .clk(clk), .reset(reset), .bus(bus), .pc(pc), .halted(halted)
   );
   hack_cpu_mc #(.DATA_W(16), .ADDR_W(4)) us (
      .clk(clk), .reset(sreset), .bus(sbus), .pc(spc), .halted(shalted)
   );

   logic [15:0] rom [0:255];
   logic [15:0] mem [0:255];
   int  iLat = 1;
   int  dLat = 1;
   bit  lateAck = 1'b0;
   int  errors = 0;
   int  checks = 0;
   int  cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   // instruction memory: ack iLat cycles after the request rises
   initial begin
      int cnt;
      cnt = 0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.imem_ack = 1'b0; cnt = 0;
         end else if (bus.imem_ack) begin
            bus.imem_ack = 1'b0; cnt = 0;
         end else if (bus.imem_req) begin
            cnt++;
            if (cnt > iLat) begin
               bus.imem_ack = 1'b1;
               bus.imem_rdata = rom[bus.imem_addr[7:0]];
            end
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0;
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.dmem_ack = 1'b0; cnt = 0;
         end else if (lateAck) begin
            bus.dmem_ack = 1'b1; lateAck = 1'b0;
         end else if (bus.dmem_ack) begin
            bus.dmem_ack = 1'b0; cnt = 0;
         end else if (bus.dmem_rd || bus.dmem_wr) begin
            cnt++;
            if (cnt > dLat) begin
               bus.dmem_ack = 1'b1;
               if (bus.dmem_wr) mem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
               else             bus.dmem_rdata = mem[bus.dmem_addr[7:0]];
            end
         end
      end
   end

   // small core fetches @1 everywhere
   initial begin
      int cnt;
      cnt = 0;
      sbus.imem_ack = 1'b0;
      sbus.imem_rdata = 16'h0001;
      sbus.dmem_ack = 1'b0;
      sbus.dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (sreset || sbus.imem_ack) begin
            sbus.imem_ack = 1'b0; cnt = 0;
         end else if (sbus.imem_req) begin
            cnt++;
            if (cnt > 1) sbus.imem_ack = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic waitFetch(input logic [14:0] addr, output int cyc, output bit ok);
      bit prev;
      prev = bus.imem_req;
      ok = 1'b0;
      cyc = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         cyc++;
         if (bus.imem_req && !prev && bus.imem_addr == addr) begin
            ok = 1'b1;
            break;
         end
         prev = bus.imem_req;
      end
   endtask

   task automatic waitWr(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.dmem_wr) begin ok = 1'b1; break; end
      end
   endtask

   task automatic restart();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int cyc, t1, rises;
      bit ok, prev;
      for (int i = 0; i < 256; i++) begin rom[i] = 16'h0000; mem[i] = 16'h0000; end

      // boot and A-instruction program: @5, D=A, A=D+1
      rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE7E0;
      repeat (3) @(negedge clk);
      check("rst_imem_req", bus.imem_req, 0);
      check("rst_dmem_rd", bus.dmem_rd, 0);
      check("rst_dmem_wr", bus.dmem_wr, 0);
      check("rst_pc", pc, 0);
      check("rst_halted", halted, 0);
      reset = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (bus.imem_req) begin ok = 1'b1; break; end
      end
      check("boot_req", ok, 1);
      check("boot_addr", bus.imem_addr, 0);
      check("boot_a", dut.aReg, 0);
      check("boot_d", dut.dReg, 0);
      waitFetch(15'd1, cyc, ok); check("ainst_ok", ok, 1); check("ainst_cyc", cyc, 3);
      waitFetch(15'd2, cyc, ok); check("cinst1_ok", ok, 1); check("cinst1_cyc", cyc, 4);
      waitFetch(15'd3, cyc, ok); check("cinst2_ok", ok, 1); check("cinst2_cyc", cyc, 4);
      check("prog1_d", dut.dReg, 16'd5);
      check("prog1_a", dut.aReg, 16'd6);
      check("prog1_pc", pc, 3);

      // PC wrap on a 4-bit address core
      sreset = 1'b0;
      prev = sbus.imem_req; ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (sbus.imem_req && !prev && sbus.imem_addr == 4'd15) begin ok = 1'b1; break; end
         prev = sbus.imem_req;
      end
      check("wrap_reach15", ok, 1);
      prev = sbus.imem_req; ok = 1'b0; cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cyc++;
         if (sbus.imem_req && !prev) begin ok = 1'b1; break; end
         prev = sbus.imem_req;
      end
      check("wrap_rise", ok, 1);
      check("wrap_addr", sbus.imem_addr, 0);
      check("wrap_cyc", cyc, 3);
      check("wrap_pc", spc, 0);
      check("wrap_a", us.aReg, 1);
      sreset = 1'b1;

      // M read then write with a 3-cycle data latency: @100, M=M+1
      rom[0] = 16'h0064; rom[1] = 16'hFDC8; rom[2] = 16'h0000;
      mem[100] = 16'h7FFF; dLat = 3;
      restart();
      waitFetch(15'd1, cyc, ok); check("rw_f1", ok, 1);
      t1 = cycle;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.dmem_rd) begin ok = 1'b1; break; end
      end
      check("rw_rd_seen", ok, 1);
      check("rw_rd_addr", bus.dmem_addr, 100);
      waitWr(ok);
      check("rw_wr_seen", ok, 1);
      check("rw_wr_addr", bus.dmem_addr, 100);
      check("rw_wdata", bus.dmem_wdata, 16'h8000);
      check("rw_pc_hold", pc, 1);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.dmem_ack) begin ok = 1'b1; break; end
      end
      check("rw_ack_seen", ok, 1);
      check("rw_wdata_stable", bus.dmem_wdata, 16'h8000);
      check("rw_addr_stable", bus.dmem_addr, 100);
      check("rw_pc_at_ack", pc, 1);
      waitFetch(15'd2, cyc, ok); check("rw_f2", ok, 1);
      check("rw_cyc", cycle - t1, 12);
      check("rw_mem", mem[100], 16'h8000);

      // AM=D;JLT with D=-3 jumps to the old A
      rom[0] = 16'h0003; rom[1] = 16'hECD0; rom[2] = 16'h0014; rom[3] = 16'hE32C;
      mem[20] = 16'h0000; dLat = 1;
      restart();
      waitWr(ok);
      check("jlt_wr_seen", ok, 1);
      check("jlt_wr_addr", bus.dmem_addr, 20);
      check("jlt_wdata", bus.dmem_wdata, 16'hFFFD);
      waitFetch(15'd20, cyc, ok); check("jlt_taken", ok, 1);
      check("jlt_pc", pc, 20);
      check("jlt_a", dut.aReg, 16'hFFFD);
      check("jlt_mem", mem[20], 16'hFFFD);

      // same with D=+3: no jump
      rom[1] = 16'hEC10;
      restart();
      waitWr(ok);
      check("jnt_wdata", bus.dmem_wdata, 16'h0003);
      waitFetch(15'd4, cyc, ok); check("jnt_next", ok, 1);
      check("jnt_pc", pc, 4);
      check("jnt_a", dut.aReg, 16'h0003);
      check("jnt_mem", mem[20], 16'h0003);

      // async reset while a write is pending
      rom[0] = 16'h0064; rom[1] = 16'hFDC8; rom[2] = 16'h0000; rom[3] = 16'h0000;
      mem[100] = 16'h1234; dLat = 6;
      restart();
      waitWr(ok);
      check("rst_wr_seen", ok, 1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_wr_drop", bus.dmem_wr, 0);
      check("rst_rd_drop", bus.dmem_rd, 0);
      check("rst_ireq_drop", bus.imem_req, 0);
      check("rst_mem_keep", mem[100], 16'h1234);
      repeat (2) @(negedge clk);
      dLat = 1;
      reset = 1'b0;
      lateAck = 1'b1;
      waitFetch(15'd0, cyc, ok); check("rst_refetch", ok, 1);
      check("rst_a_clear", dut.aReg, 0);
      check("rst_d_clear", dut.dReg, 0);
      check("rst_no_wr", bus.dmem_wr, 0);
      waitFetch(15'd2, cyc, ok); check("rst_rerun", ok, 1);
      check("rst_mem_new", mem[100], 16'h1235);

      // self-loop: @7 at PC 6, 0;JMP at PC 7
      for (int i = 0; i < 6; i++) rom[i] = 16'h0000;
      rom[6] = 16'h0007; rom[7] = 16'hEA87;
      restart();
      waitFetch(15'd7, cyc, ok); check("loop_f7", ok, 1);
`ifdef HACK_CPU_HALT_EN
      rises = 0; prev = bus.imem_req;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.imem_req && !prev) rises++;
         prev = bus.imem_req;
      end
      check("halt_no_req", rises, 0);
      check("halt_flag", halted, 1);
      check("halt_pc", pc, 7);
`else
      rises = 0;
      waitFetch(15'd7, cyc, ok); check("loop_again1", ok, 1); check("loop_cyc1", cyc, 4);
      waitFetch(15'd7, cyc, ok); check("loop_again2", ok, 1); check("loop_cyc2", cyc, 4);
      check("loop_halted", halted, rises);
      check("loop_pc", pc, 7);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
